// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl_unit                                              |
// | Description : Pipeline hazard controller: memory-wait freeze, redirect      |
// |               flush, load-use bubble and saturating per-cause counters.     |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module hazard_ctrl_unit #(
  parameter int REG_AW    = 5,
  parameter int MEM_LAT   = 2,
  parameter int STORE_FWD = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_rs1,
  input  logic [REG_AW-1:0] IF_ID_rs2,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_mem_read,
  input  logic              ld_sd_mem_read,
  input  logic              ld_sd_mem_write,
  input  logic              pc_src,
  input  logic              EX_MEM_mem_access,
  input  logic              cnt_clr,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              ID_EX_write,
  output logic              EX_MEM_write,
  output logic              control_mux_sel,
  output logic              flush,
  output logic              MEM_WB_bubble,
  output logic [CNT_W-1:0]  cnt_load_use,
  output logic [CNT_W-1:0]  cnt_mem_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  localparam int                  c_wait_w    = $clog2(MEM_LAT) + 1;
  localparam logic [c_wait_w-1:0] c_wait_init = c_wait_w'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic                c_has_wait  = (MEM_LAT > 1);
  localparam logic                c_store_fwd = (STORE_FWD != 0);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic [c_wait_w-1:0] w_wait_cnt_nxt;
  logic                w_frz;
  logic                w_rs2_exempt;
  logic                w_load_use;
  logic [2:0]          w_evt;
  logic [CNT_W-1:0]    r_cnt [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // The access that triggers the wait is frozen in RUN; MEM_WAIT covers the
  // remaining MEM_LAT-2 frozen cycles plus one release cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_frz          = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (EX_MEM_mem_access && c_has_wait) begin
          w_frz          = 1'b1;
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = c_wait_init;
        end
      end
      ST_MEM_WAIT: begin
        if (r_wait_cnt != '0) begin
          w_frz          = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt - c_wait_w'(1);
        end else begin
          w_state_nxt    = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // rs2 of a load/store is store data and gets forwarded later in the pipe.
  assign w_rs2_exempt = c_store_fwd && (ld_sd_mem_read || ld_sd_mem_write);
  assign w_load_use   = ID_EX_mem_read && (ID_EX_rd != '0) &&
                        ((ID_EX_rd == IF_ID_rs1) ||
                         ((ID_EX_rd == IF_ID_rs2) && !w_rs2_exempt));

  always_comb begin
    pc_write        = 1'b1;
    IF_ID_write     = 1'b1;
    ID_EX_write     = 1'b1;
    EX_MEM_write    = 1'b1;
    control_mux_sel = 1'b0;
    flush           = 1'b0;
    MEM_WB_bubble   = 1'b0;
    if (!rst_n || w_frz) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (pc_src) begin
      flush           = 1'b1;
    end else if (w_load_use) begin
      pc_write        = 1'b0;
      IF_ID_write     = 1'b0;
      control_mux_sel = 1'b1;
    end
  end

  assign w_evt = {flush, w_frz, control_mux_sel};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt[gi] <= '0;
      end else if (cnt_clr) begin
        r_cnt[gi] <= '0;
      end else if (w_evt[gi] && (r_cnt[gi] != '1)) begin
        r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
      end
    end
  end

  assign cnt_load_use  = r_cnt[0];
  assign cnt_mem_stall = r_cnt[1];
  assign cnt_flush     = r_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl_unit                                           |
// | Description : Self-checking bench for two hazard_ctrl_unit configurations.  |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl_unit;

  localparam int c_lat_a = 3;
  localparam int c_lat_b = 4;
  localparam int c_sfw_a = 1;
  localparam int c_sfw_b = 0;
  localparam int c_cw_a  = 4;
  localparam int c_cw_b  = 16;

  // {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, control_mux_sel, flush, MEM_WB_bubble}
  localparam logic [6:0] c_o_def = 7'b1111000;
  localparam logic [6:0] c_o_lu  = 7'b0011100;
  localparam logic [6:0] c_o_fl  = 7'b1111010;
  localparam logic [6:0] c_o_frz = 7'b0000001;
  localparam logic [6:0] c_o_rst = 7'b0000001;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       ld;
    logic       sd;
    logic       pc;
    logic       acc;
    logic       clr;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
  } vec_t;

  logic        clk;
  logic        rst_n;
  in_t         din [2];
  logic        pcw [2];
  logic        ifw [2];
  logic        idw [2];
  logic        exw [2];
  logic        cms [2];
  logic        fl  [2];
  logic        bub [2];
  logic [3:0]  a_lu, a_ms, a_fl;
  logic [15:0] b_lu, b_ms, b_fl;

  int n_checks;
  int n_fail;
  int m_busy [2];
  int m_cnt  [2][3];
  vec_t tbl [$];

  hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(c_lat_a), .STORE_FWD(c_sfw_a), .CNT_W(c_cw_a)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(din[0].rs1), .IF_ID_rs2(din[0].rs2), .ID_EX_rd(din[0].rd),
    .ID_EX_mem_read(din[0].mr), .ld_sd_mem_read(din[0].ld), .ld_sd_mem_write(din[0].sd),
    .pc_src(din[0].pc), .EX_MEM_mem_access(din[0].acc), .cnt_clr(din[0].clr),
    .pc_write(pcw[0]), .IF_ID_write(ifw[0]), .ID_EX_write(idw[0]), .EX_MEM_write(exw[0]),
    .control_mux_sel(cms[0]), .flush(fl[0]), .MEM_WB_bubble(bub[0]),
    .cnt_load_use(a_lu), .cnt_mem_stall(a_ms), .cnt_flush(a_fl)
  );

  hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(c_lat_b), .STORE_FWD(c_sfw_b), .CNT_W(c_cw_b)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(din[1].rs1), .IF_ID_rs2(din[1].rs2), .ID_EX_rd(din[1].rd),
    .ID_EX_mem_read(din[1].mr), .ld_sd_mem_read(din[1].ld), .ld_sd_mem_write(din[1].sd),
    .pc_src(din[1].pc), .EX_MEM_mem_access(din[1].acc), .cnt_clr(din[1].clr),
    .pc_write(pcw[1]), .IF_ID_write(ifw[1]), .ID_EX_write(idw[1]), .EX_MEM_write(exw[1]),
    .control_mux_sel(cms[1]), .flush(fl[1]), .MEM_WB_bubble(bub[1]),
    .cnt_load_use(b_lu), .cnt_mem_stall(b_ms), .cnt_flush(b_fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return (k == 0) ? c_lat_a : c_lat_b;
  endfunction

  function automatic int cmax_of(int k);
    return (k == 0) ? ((1 << c_cw_a) - 1) : ((1 << c_cw_b) - 1);
  endfunction

  function automatic logic [6:0] dut_out(int k);
    return {pcw[k], ifw[k], idw[k], exw[k], cms[k], fl[k], bub[k]};
  endfunction

  function automatic logic [31:0] dut_cnt(int k, int w);
    if (k == 0) return (w == 0) ? 32'(a_lu) : (w == 1) ? 32'(a_ms) : 32'(a_fl);
    return (w == 0) ? 32'(b_lu) : (w == 1) ? 32'(b_ms) : 32'(b_fl);
  endfunction

  function automatic in_t mk_in(int rs1, int rs2, int rd, bit mr, bit ld, bit sd, bit pc);
    in_t v;
    v     = '0;
    v.rs1 = 5'(rs1);
    v.rs2 = 5'(rs2);
    v.rd  = 5'(rd);
    v.mr  = mr;
    v.ld  = ld;
    v.sd  = sd;
    v.pc  = pc;
    return v;
  endfunction

  // Reference: m_busy counts the cycles left in the current memory window
  // (frozen cycles followed by one release cycle); 0 means no access pending.
  function automatic logic [6:0] model_out(int k);
    bit frz;
    bit rs2_live;
    bit lu;
    if (!rst_n) return c_o_rst;
    frz      = (m_busy[k] == 0) ? (din[k].acc && lat_of(k) > 1) : (m_busy[k] > 1);
    rs2_live = !((k == 0 ? c_sfw_a : c_sfw_b) != 0 && (din[k].ld || din[k].sd));
    lu       = din[k].mr && din[k].rd != 0 &&
               (din[k].rd == din[k].rs1 || (din[k].rd == din[k].rs2 && rs2_live));
    if (frz)       return c_o_frz;
    if (din[k].pc) return c_o_fl;
    if (lu)        return c_o_lu;
    return c_o_def;
  endfunction

  task automatic model_step(int k);
    logic [6:0] o;
    bit         ev [3];
    o     = model_out(k);
    ev[0] = o[2];
    ev[1] = o[0];
    ev[2] = o[1];
    if (m_busy[k] == 0) m_busy[k] = (din[k].acc && lat_of(k) > 1) ? lat_of(k) - 1 : 0;
    else                m_busy[k] = m_busy[k] - 1;
    for (int j = 0; j < 3; j++) begin
      if (din[k].clr)                             m_cnt[k][j] = 0;
      else if (ev[j] && m_cnt[k][j] < cmax_of(k)) m_cnt[k][j] = m_cnt[k][j] + 1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0;
      for (int j = 0; j < 3; j++) m_cnt[k][j] = 0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compares both DUTs against the model at the falling edge, then advances
  // the model and returns 1 time unit after the next rising edge.
  task automatic cycle(string tag);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_out%0d", tag, k), 32'(dut_out(k)), 32'(model_out(k)));
      chk($sformatf("%s_lu%0d", tag, k), dut_cnt(k, 0), 32'(m_cnt[k][0]));
      chk($sformatf("%s_ms%0d", tag, k), dut_cnt(k, 1), 32'(m_cnt[k][1]));
      chk($sformatf("%s_fl%0d", tag, k), dut_cnt(k, 2), 32'(m_cnt[k][2]));
      model_step(k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(string tag);
    din[0] = '0;
    din[1] = '0;
    rst_n  = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_rst_out%0d", tag, k), 32'(dut_out(k)), 32'(c_o_rst));
      chk($sformatf("%s_rst_ms%0d", tag, k), dut_cnt(k, 1), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    din[0]   = '0;
    din[1]   = '0;
    model_reset();

    tbl.push_back('{mk_in(5, 0, 5, 1, 0, 0, 0), c_o_lu,  c_o_lu });
    tbl.push_back('{mk_in(0, 0, 0, 1, 0, 0, 0), c_o_def, c_o_def});
    tbl.push_back('{mk_in(1, 7, 7, 1, 0, 1, 0), c_o_def, c_o_lu });
    tbl.push_back('{mk_in(1, 7, 7, 1, 1, 0, 0), c_o_def, c_o_lu });
    tbl.push_back('{mk_in(1, 7, 7, 1, 0, 0, 0), c_o_lu,  c_o_lu });
    tbl.push_back('{mk_in(5, 0, 5, 0, 0, 0, 0), c_o_def, c_o_def});
    tbl.push_back('{mk_in(5, 0, 5, 1, 0, 0, 1), c_o_fl,  c_o_fl });
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 1), c_o_fl,  c_o_fl });
    tbl.push_back('{mk_in(4, 2, 3, 1, 0, 0, 0), c_o_def, c_o_def});

    // Reset state while rst_n is held low across clock edges.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("init_out%0d", k), 32'(dut_out(k)), 32'(c_o_rst));
      for (int j = 0; j < 3; j++) chk($sformatf("init_cnt%0d_%0d", k, j), dut_cnt(k, j), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Priority / load-use / store-forward vectors, no memory access.
    for (int i = 0; i < tbl.size(); i++) begin
      din[0] = tbl[i].in;
      din[1] = tbl[i].in;
      #1;
      chk($sformatf("tbl%0d_a", i), 32'(dut_out(0)), 32'(tbl[i].exp_a));
      chk($sformatf("tbl%0d_b", i), 32'(dut_out(1)), 32'(tbl[i].exp_b));
      cycle("tbl");
    end
    din[0] = '0;
    din[1] = '0;
    #1;
    chk("tbl_cnt_lu_a", dut_cnt(0, 0), 32'd2);
    chk("tbl_cnt_lu_b", dut_cnt(1, 0), 32'd4);
    chk("tbl_cnt_fl_a", dut_cnt(0, 2), 32'd2);

    // MEM_LAT=3 single access: frozen cycles 0-1, release at 2.
    do_reset("s1");
    din[0].acc = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("s1_c%0d", c), 32'(dut_out(0)), 32'((c < 2) ? c_o_frz : c_o_def));
      cycle("s1");
    end
    din[0].acc = 1'b0;
    #1;
    chk("s1_run", 32'(dut_out(0)), 32'(c_o_def));
    chk("s1_ms", dut_cnt(0, 1), 32'd2);
    cycle("s1");

    // MEM_LAT=4 access with a pending redirect: flush deferred to release.
    do_reset("s2");
    din[1].acc = 1'b1;
    din[1].pc  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("s2_c%0d", c), 32'(dut_out(1)), 32'((c < 3) ? c_o_frz : c_o_fl));
      cycle("s2");
    end
    din[1] = '0;
    #1;
    chk("s2_fl", dut_cnt(1, 2), 32'd1);
    chk("s2_ms", dut_cnt(1, 1), 32'd3);
    cycle("s2");

    // Asynchronous reset while waiting on memory (wait_cnt=1).
    do_reset("s3");
    din[0].acc = 1'b1;
    cycle("s3");
    #1;
    chk("s3_wait", 32'(dut_out(0)), 32'(c_o_frz));
    #1;
    rst_n = 1'b0;
    #1;
    chk("s3_rst_a", 32'(dut_out(0)), 32'(c_o_rst));
    chk("s3_rst_b", 32'(dut_out(1)), 32'(c_o_rst));
    chk("s3_rst_ms", dut_cnt(0, 1), 32'd0);
    model_reset();
    din[0].acc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s3_after", 32'(dut_out(0)), 32'(c_o_def));
    cycle("s3");

    // 4-bit counter saturation and clear-over-increment.
    do_reset("s4");
    din[0] = mk_in(5, 0, 5, 1, 0, 0, 0);
    for (int c = 0; c < 20; c++) cycle("s4");
    chk("s4_sat", dut_cnt(0, 0), 32'd15);
    din[0].clr = 1'b1;
    cycle("s4");
    chk("s4_clr", dut_cnt(0, 0), 32'd0);
    din[0].clr = 1'b0;
    cycle("s4");

    // Randomised traffic on both configurations.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        din[k].rs1 = 5'($urandom_range(0, 3));
        din[k].rs2 = 5'($urandom_range(0, 3));
        din[k].rd  = 5'($urandom_range(0, 3));
        din[k].mr  = ($urandom_range(0, 1) == 1);
        din[k].ld  = ($urandom_range(0, 2) == 0);
        din[k].sd  = ($urandom_range(0, 2) == 0);
        din[k].pc  = ($urandom_range(0, 5) == 0);
        din[k].acc = ($urandom_range(0, 3) == 0);
        din[k].clr = ($urandom_range(0, 40) == 0);
      end
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage core, successor to the combinational load-use/flush detector. Adds a fixed-latency data-memory wait FSM that freezes the whole pipeline, a store-data exemption mode, and saturating per-cause stall/flush counters for performance analysis. Sits beside the decode stage and drives the PC, all pipeline-register write enables, the ID/EX bubble mux and the flush lines.

## Interface
- REG_AW, 5: register address width.
- MEM_LAT, 2: data-memory latency in cycles, 1..16; 1 means no memory freeze.
- STORE_FWD, 1: 1 exempts `IF_ID_rs2` from load-use checks when the decode instruction is a load or store (rs2 is store data, forwarded later); 0 checks rs2 always.
- CNT_W, 16: width of each statistics counter.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_ID_rs1, IF_ID_rs2  in  REG_AW  source registers of the instruction in decode.
- ID_EX_rd  in  REG_AW  destination of the instruction in EX.
- ID_EX_mem_read  in  1  EX instruction is a load.
- ld_sd_mem_read, ld_sd_mem_write  in  1  decode instruction is a load / store.
- pc_src  in  1  taken branch/jump resolved in EX; held stable while EX is frozen.
- EX_MEM_mem_access  in  1  MEM-stage instruction is a load or store.
- cnt_clr  in  1  synchronous clear of all counters.
- pc_write, IF_ID_write, ID_EX_write, EX_MEM_write  out  1  register write enables.
- control_mux_sel  out  1  inject bubble into ID/EX.
- flush  out  1  clear IF/ID and ID/EX.
- MEM_WB_bubble  out  1  write a bubble into MEM/WB.
- cnt_load_use, cnt_mem_stall, cnt_flush  out  CNT_W  event counters.

## Operation
- FSM states: RUN, MEM_WAIT; down-counter `wait_cnt`, width ceil(log2(MEM_LAT))+1.
- Freeze condition `frz`: (state==RUN && EX_MEM_mem_access && MEM_LAT>1) || (state==MEM_WAIT && wait_cnt!=0).
- RUN, access with MEM_LAT>1: frz this cycle; load wait_cnt=MEM_LAT-2; go MEM_WAIT.
- MEM_WAIT: wait_cnt!=0 → frz, decrement; wait_cnt==0 → release (no frz), go RUN. Same instruction never retriggers.
- Total frozen cycles per access = MEM_LAT-1; MEM_LAT=1 never leaves RUN.
- Output priority, highest first:
  - frz: all four write enables 0, MEM_WB_bubble=1, flush=0, control_mux_sel=0.
  - pc_src: flush=1, all write enables 1 (redirect).
  - load-use: ID_EX_mem_read && ID_EX_rd!=0 && (ID_EX_rd==IF_ID_rs1 || (ID_EX_rd==IF_ID_rs2 && !(STORE_FWD && (ld_sd_mem_read||ld_sd_mem_write)))) → pc_write=0, IF_ID_write=0, control_mux_sel=1, ID_EX_write=EX_MEM_write=1.
  - default: all write enables 1, others 0.
- Redirect or load-use coinciding with frz is deferred; inputs stay stable because EX/ID are frozen, so they resolve on the release cycle.
- Counters: cnt_mem_stall +1 per frz cycle; cnt_load_use +1 per load-use bubble cycle; cnt_flush +1 per flush cycle. Saturate at all-ones. cnt_clr has priority over increment.

## Timing
- Outputs are combinational from inputs and registered state; zero-cycle response.
- State, wait_cnt, counters update on rising clk edge.
- Reset (rst_n low, asynchronous): state=RUN, wait_cnt=0, counters=0; outputs forced to pc_write=IF_ID_write=ID_EX_write=EX_MEM_write=0, control_mux_sel=0, flush=0, MEM_WB_bubble=1.
- Reset mid MEM_WAIT aborts the wait; first cycle after release obeys RUN rules.
- Back-to-back memory ops: release cycle advances next op into MEM; it triggers a new freeze on the following cycle.

## Test plan
- MEM_LAT=3, single load in MEM at cycle 0 → frz cycles 0–1, release cycle 2; cnt_mem_stall=2; state back to RUN at cycle 3.
- ID_EX_mem_read=1, ID_EX_rd=5, IF_ID_rs1=5, no access → pc_write=0, IF_ID_write=0, control_mux_sel=1 for one cycle; cnt_load_use=1. Same with ID_EX_rd=0 → no stall.
- STORE_FWD=1, ID_EX_rd=7=IF_ID_rs2, ld_sd_mem_write=1 → no stall; STORE_FWD=0 same stimulus → stall.
- pc_src=1 together with MEM_LAT=4 access → flush=0 for 3 frozen cycles, flush=1 on release cycle; cnt_flush=1.
- rst_n dropped during MEM_WAIT (wait_cnt=1) → outputs immediately at reset values; after release, no freeze unless EX_MEM_mem_access=1.
- CNT_W=4, 20 consecutive load-use cycles → cnt_load_use stops at 15; cnt_clr pulse → 0 next edge.
